lif_spike_monitor: RTL and testbench
====================================

# lif_spike_monitor

Downstream observer for the LIF neuron core. Consumes the neuron's per-cycle membrane output (`vout`, Q1.6.9 signed) and `spike` flag while the core is in its run phase. Produces:
- timestamped spike events through a small FIFO;
- the last inter-spike interval (ISI);
- a windowed spike-rate count;
- optionally, the peak membrane voltage.

This lets the tile's output logic or a host read neuron activity without sampling every cycle.

## Interface
Parameters
- `TS_W`, 16: timestamp and ISI width in bits.
- `DEPTH`, 8: spike FIFO depth in entries. Must be a power of two, ≥2.
- `WIN_W`, 8: width of the window length and of the rate count.

Ports
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear, active high.
- `valid_in` in 1: neuron is in its run phase; `vout_in` and `spike_in` are meaningful.
- `spike_in` in 1: neuron fired this cycle.
- `vout_in` in 16: signed membrane voltage, Q1.6.9.
- `win_len` in WIN_W: rate window length in valid cycles. 0 disables rate measurement.
- `rd_en` in 1: pop the FIFO head.
- `rd_data` out TS_W: FIFO head timestamp, first-word-fall-through.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `overflow` out 1: sticky flag; a spike was dropped because the FIFO was full.
- `isi` out TS_W: interval between the last two spikes.
- `isi_valid` out 1: at least two spikes have been seen since reset or clear.
- `rate` out WIN_W: spike count of the last completed window.
- `rate_valid` out 1: one-cycle pulse when `rate` updates.
- `v_peak` out 16: maximum signed `vout_in` seen during run.

## Operation
- FSM states:
  - IDLE: counters hold.
  - RUN: go from IDLE to RUN on `valid_in`=1. Go from RUN to IDLE on `valid_in`=0.
  - RUN→IDLE discards the partial window count and the window counter. The timestamp, FIFO, ISI and peak are kept.
- Timestamp `ts`:
  - increments every cycle that `valid_in`=1;
  - wraps modulo 2^TS_W;
  - the event logged for a spike is the `ts` value before that cycle's increment.
- FIFO push: on `valid_in & spike_in`.
  - If not full, or if full with `rd_en` asserted in the same cycle, the push succeeds.
  - Otherwise the spike is dropped and `overflow` is set.
- FIFO pop: on `rd_en & !empty`.
  - `rd_en` while empty is ignored; pointers and `rd_data` are unchanged.
- Simultaneous push and pop: occupancy is unchanged and both operations take effect.
- `spike_in` with `valid_in`=0 is ignored by all functions.
- ISI:
  - every valid spike updates `isi` ← (`ts` − `last_ts`) mod 2^TS_W, then `last_ts` ← `ts`;
  - the first spike after reset or clear only loads `last_ts`;
  - `isi_valid` sets on the second spike.
- Rate window:
  - `win_cnt` counts valid cycles from 0 up to `win_len`−1. `spk_cnt` counts valid spikes in the window and saturates at 2^WIN_W−1.
  - On the terminal cycle: `rate` ← final `spk_cnt`, including a spike in that cycle; pulse `rate_valid`; restart both counters.
  - A change of `win_len` mid-window takes effect on the next comparison.
- `clr` takes priority over all same-cycle events. It empties the FIFO and clears `ts`, `overflow`, `isi`, `isi_valid`, `last_ts`, `rate`, the counters and `v_peak`, and sends the FSM to IDLE.

## Timing
- Reset values:
  - `rd_data`, `full`, `overflow`, `isi`, `isi_valid`, `rate`, `rate_valid` = 0;
  - `empty` = 1;
  - `v_peak` = 16'h8000.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Spike at edge t: `empty`=0 and `rd_data` are valid after edge t, i.e. visible in cycle t+1. `isi` is updated at the same edge.
- Pop at edge t: the next head appears in cycle t+1.
- `rate_valid` is high for exactly the cycle after the window's terminal cycle.
- `full` and `empty` are registered and track occupancy with no extra lag beyond the edge.

## Configuration
- `LIF_MON_PEAK_EN` defined:
  - `v_peak` is a register updated to `vout_in` when `valid_in` is high and `vout_in` > `v_peak` (signed);
  - it is cleared to 16'h8000 by reset or `clr`.
- Not defined: `v_peak` is tied to constant 16'h8000 and no peak logic is synthesised.

## Test plan
- Reset, then `valid_in`=1 with spikes at `ts`=3, 10 and 25 → FIFO pops give 3, 10, 25; `isi`=15; `isi_valid`=1 after the second spike.
- Fill the FIFO with 8 spikes and leave it unread, then inject a 9th spike → `full`=1, `overflow`=1, and the popped sequence is the first 8 timestamps.
- With the FIFO full, assert spike and `rd_en` in the same cycle → no overflow, `full` stays 1, and the new timestamp is the tail.
- `win_len`=10 with spikes on 4 of each 10 valid cycles → `rate`=4 and `rate_valid` pulses every 10 cycles. Drop `valid_in` at cycle 5 → no pulse, and the count restarts.
- Force `ts` wrap with `TS_W`=4 and spikes at `ts`=14 and 2 → `isi`=4.
- With `LIF_MON_PEAK_EN` set, drive `vout_in` = 16'hF000, 16'h0400, 16'h0200 → `v_peak`=16'h0400. `clr` → `v_peak`=16'h8000 and `empty`=1.

Source files
------------

// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: observes the LIF core's run-phase output and records
// spike timestamps (FWFT FIFO), the last inter-spike interval, a windowed
// spike rate and, with LIF_MON_PEAK_EN defined, the peak membrane voltage.
module lif_spike_monitor #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             valid_in,
    input  logic             spike_in,
    input  logic [15:0]      vout_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             rd_en,
    output logic [TS_W-1:0]  rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [TS_W-1:0]  isi,
    output logic             isi_valid,
    output logic [WIN_W-1:0] rate,
    output logic             rate_valid,
    output logic [15:0]      v_peak
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [15:0] V_MIN = 16'h8000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;
    logic   win_discard;

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  last_ts;
    logic             have_last;

    logic [TS_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nx;
    logic [TS_W-1:0]  rd_data_nx;

    logic             spike_v;
    logic             push;
    logic             pop;
    logic             drop;

    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] spk_cnt;
    logic [WIN_W-1:0] spk_sum;
    logic             win_term;

    // Run-phase state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; leaving RUN throws away the partial rate window
    always_comb begin
        state_nx    = state;
        win_discard = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!valid_in) begin
                    state_nx    = IDLE;
                    win_discard = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clr) begin
            state_nx = IDLE;
        end
    end

    // FIFO handshake, next head and window arithmetic
    always_comb begin
        spike_v   = valid_in & spike_in;
        pop       = rd_en & ~empty;
        push      = spike_v & (~full | rd_en);
        drop      = spike_v & full & ~rd_en;
        count_nx  = count + CW'(push) - CW'(pop);
        rd_ptr_nx = pop ? rd_ptr + AW'(1) : rd_ptr;

        // A push into a FIFO that is (or is about to be) empty becomes the head
        rd_data_nx = rd_data;
        if (push && ((count - CW'(pop)) == '0)) begin
            rd_data_nx = ts;
        end else if (count_nx != '0) begin
            rd_data_nx = mem[rd_ptr_nx];
        end

        spk_sum = spk_cnt;
        if (spike_in && (spk_cnt != '1)) begin
            spk_sum = spk_cnt + WIN_W'(1);
        end
        win_term = (win_len != '0) && (win_cnt >= (win_len - WIN_W'(1)));
    end

    // Timestamp storage; contents need no reset, pointers and count guard them
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= ts;
        end
    end

    // FIFO pointers, occupancy flags, head register and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nx;
            count   <= count_nx;
            rd_data <= rd_data_nx;
            empty   <= (count_nx == '0);
            full    <= (count_nx == CNT_FULL);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Timestamp counter and inter-spike interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts        <= '0;
            last_ts   <= '0;
            have_last <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else if (clr) begin
            ts        <= '0;
            last_ts   <= '0;
            have_last <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else begin
            if (valid_in) begin
                ts <= ts + TS_W'(1);
            end
            if (spike_v) begin
                if (have_last) begin
                    isi       <= ts - last_ts;
                    isi_valid <= 1'b1;
                end
                last_ts   <= ts;
                have_last <= 1'b1;
            end
        end
    end

    // Rate window: count valid cycles and spikes, publish on the terminal cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else if (clr) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (win_discard || (win_len == '0)) begin
                win_cnt <= '0;
                spk_cnt <= '0;
            end else if (valid_in) begin
                if (win_term) begin
                    rate       <= spk_sum;
                    rate_valid <= 1'b1;
                    win_cnt    <= '0;
                    spk_cnt    <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    spk_cnt <= spk_sum;
                end
            end
        end
    end

`ifdef LIF_MON_PEAK_EN
    // Signed running maximum of the membrane voltage during run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_peak <= V_MIN;
        end else if (clr) begin
            v_peak <= V_MIN;
        end else if (valid_in && ($signed(vout_in) > $signed(v_peak))) begin
            v_peak <= vout_in;
        end
    end
`else
    // Peak tracking not built: report the most negative value
    logic vout_unused;
    assign vout_unused = ^vout_in;
    assign v_peak      = V_MIN;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Scoreboard bench for lif_spike_monitor. A 16-bit-timestamp instance and a
// 4-bit-timestamp instance share stimulus; the narrow one exercises wrap.
module tb_lif_spike_monitor;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIN_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid_in = 1'b0;
    logic        spike_in = 1'b0;
    logic [15:0] vout_in = 16'h0;
    logic [7:0]  win_len = 8'd0;
    logic        rd_en = 1'b0;

    logic [15:0] rd_data, isi, v_peak;
    logic        empty, full, overflow, isi_valid, rate_valid;
    logic [7:0]  rate;
    logic [3:0]  rd_data4, isi4;
    logic        empty4, full4, overflow4, isi_valid4, rate_valid4;
    logic [7:0]  rate4;
    logic [15:0] v_peak4;

    lif_spike_monitor #(.TS_W(16), .DEPTH(DEPTH), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .spike_in(spike_in),
        .vout_in(vout_in), .win_len(win_len), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .overflow(overflow), .isi(isi),
        .isi_valid(isi_valid), .rate(rate), .rate_valid(rate_valid), .v_peak(v_peak)
    );

    lif_spike_monitor #(.TS_W(4), .DEPTH(DEPTH), .WIN_W(WIN_W)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .valid_in(valid_in), .spike_in(spike_in),
        .vout_in(vout_in), .win_len(win_len), .rd_en(rd_en), .rd_data(rd_data4),
        .empty(empty4), .full(full4), .overflow(overflow4), .isi(isi4),
        .isi_valid(isi_valid4), .rate(rate4), .rate_valid(rate_valid4), .v_peak(v_peak4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        empty;
        logic        full;
        logic        overflow;
        logic        isi_valid;
        logic        rate_valid;
        logic [15:0] isi;
        logic [15:0] v_peak;
    } status_t;

    logic [15:0] fifo_q[$];
    logic [7:0]  rate_q[$];
    status_t     stat_q[$];

    // Reference model state
    logic [15:0] m_ts;
    int          m_occ;
    logic        m_ovf;
    logic        m_have_last;
    logic [15:0] m_last;
    logic [15:0] m_isi;
    logic        m_isi_valid;
    logic [15:0] m_peak;
    bit          win_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ts = '0; m_occ = 0; m_ovf = 1'b0; m_have_last = 1'b0; m_last = '0;
        m_isi = '0; m_isi_valid = 1'b0; m_peak = 16'h8000;
        fifo_q.delete();
        win_q.delete();
    endtask

    task automatic push_status(input logic rv);
        status_t st;
        st.empty      = (m_occ == 0);
        st.full       = (m_occ == DEPTH);
        st.overflow   = m_ovf;
        st.isi_valid  = m_isi_valid;
        st.rate_valid = rv;
        st.isi        = m_isi;
        st.v_peak     = m_peak;
        stat_q.push_back(st);
    endtask

    // One clock of stimulus; the model advances to the state after the next edge
    task automatic step(input logic v, input logic s, input logic [15:0] vo, input logic rd);
        logic pop;
        logic rv;
        int   sum;
        @(negedge clk);
        valid_in = v; spike_in = s; vout_in = vo; rd_en = rd; clr = 1'b0;
        pop = rd && (m_occ > 0);
        rv  = 1'b0;
        if (v && s) begin
            if ((m_occ < DEPTH) || rd) begin
                fifo_q.push_back(m_ts);
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            if (m_have_last) begin
                m_isi       = m_ts - m_last;
                m_isi_valid = 1'b1;
            end
            m_last      = m_ts;
            m_have_last = 1'b1;
        end
        if (pop) m_occ--;
        if (v && (win_len != 0)) begin
            win_q.push_back(s);
            if (win_q.size() >= int'(win_len)) begin
                sum = 0;
                foreach (win_q[i]) sum += int'(win_q[i]);
                rate_q.push_back((sum > 255) ? 8'd255 : 8'(sum));
                rv = 1'b1;
                win_q.delete();
            end
        end else begin
            win_q.delete();
        end
`ifdef LIF_MON_PEAK_EN
        if (v && ($signed(vo) > $signed(m_peak))) m_peak = vo;
`endif
        if (v) m_ts = m_ts + 16'd1;
        push_status(rv);
    endtask

    task automatic do_clr();
        @(negedge clk);
        valid_in = 1'($urandom_range(0, 1)); spike_in = 1'b1; rd_en = 1'b0; clr = 1'b1;
        model_clear();
        push_status(1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"}, rd_data, 16'h0);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_isi"}, isi, 16'h0);
        check({tag, "_isi_valid"}, isi_valid, 1'b0);
        check({tag, "_rate"}, rate, 8'h0);
        check({tag, "_rate_valid"}, rate_valid, 1'b0);
        check({tag, "_v_peak"}, v_peak, 16'h8000);
    endtask

    // Asynchronous reset asserted between edges, released just after an edge
    task automatic do_async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("async_rst");
        valid_in = 1'b0; spike_in = 1'b0; rd_en = 1'b0; clr = 1'b0;
        model_clear();
        rate_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Monitor: FIFO pops and rate pulses, sampled with pre-edge values
    always @(posedge clk) begin
        if (rst) begin
            if (rd_en && !empty) begin
                if (fifo_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_data: got %0h with no expected entry", rd_data);
                end else begin
                    logic [15:0] exp_ts;
                    exp_ts = fifo_q.pop_front();
                    check("pop_data", rd_data, exp_ts);
                    check("pop_data_ts4", rd_data4, exp_ts[3:0]);
                end
            end
            if (rate_valid) begin
                if (rate_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rate: got %0d with no expected window", rate);
                end else begin
                    logic [7:0] exp_rate;
                    exp_rate = rate_q.pop_front();
                    check("rate", rate, exp_rate);
                    check("rate_ts4", rate4, exp_rate);
                end
            end
        end
    end

    // Monitor: post-edge status against the model's expectation for that edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (stat_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL status: got no expected entry for edge");
            end else begin
                status_t st;
                st = stat_q.pop_front();
                check("empty", empty, st.empty);
                check("full", full, st.full);
                check("overflow", overflow, st.overflow);
                check("isi", isi, st.isi);
                check("isi_valid", isi_valid, st.isi_valid);
                check("rate_valid", rate_valid, st.rate_valid);
                check("v_peak", v_peak, st.v_peak);
                check("empty_ts4", empty4, st.empty);
                check("full_ts4", full4, st.full);
                check("overflow_ts4", overflow4, st.overflow);
                check("isi_ts4", isi4, st.isi[3:0]);
                check("isi_valid_ts4", isi_valid4, st.isi_valid);
                check("rate_valid_ts4", rate_valid4, st.rate_valid);
            end
        end
    end

    initial begin
        model_clear();
        #2 rst = 1'b0;
        #1 check_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // Spikes at ts 3, 10, 25 then pop them
        for (int i = 0; i < 26; i++) step(1'b1, (i == 3) || (i == 10) || (i == 25), 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Fill to full, drop a ninth spike, drain
        do_clr();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Full FIFO with simultaneous spike and pop: no drop, stays full
        do_clr();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Timestamp wrap on the 4-bit instance: spikes at ts 14 and 18 (2 mod 16)
        do_clr();
        for (int i = 0; i < 19; i++) step(1'b1, (i == 14) || (i == 18), 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Rate window of 10 with 4 spikes per window, then an interrupted window
        do_clr();
        win_len = 8'd10;
        for (int i = 0; i < 30; i++)
            step(1'b1, ((i % 10) == 1) || ((i % 10) == 3) || ((i % 10) == 5) || ((i % 10) == 8),
                 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, (i % 2) == 0, 16'h0, 1'b1);
        win_len = 8'd0;

        // Peak voltage, then clear
        do_clr();
        step(1'b1, 1'b0, 16'hF000, 1'b0);
        step(1'b1, 1'b0, 16'h0400, 1'b0);
        step(1'b1, 1'b0, 16'h0200, 1'b0);
        step(1'b0, 1'b0, 16'h7FFF, 1'b0);
        do_clr();
        step(1'b0, 1'b0, 16'h0, 1'b0);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'h1234, 1'b0);
        do_async_reset();

        // Randomized phases with different window lengths and read pressure
        for (int ph = 0; ph < 4; ph++) begin
            int unsigned rd_pct;
            step(1'b0, 1'b0, 16'h0, 1'b0);
            case (ph)
                0: begin win_len = 8'd7;  rd_pct = 30; end
                1: begin win_len = 8'd1;  rd_pct = 70; end
                2: begin win_len = 8'd0;  rd_pct = 50; end
                default: begin win_len = 8'd13; rd_pct = 20; end
            endcase
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_clr();
                end else begin
                    step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                         16'($urandom()), $urandom_range(0, 99) < rd_pct);
                end
            end
        end

        // Drain and confirm nothing expected is left behind
        win_len = 8'd0;
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #2;
        check("fifo_leftover", 32'(fifo_q.size()), 32'd0);
        check("rate_leftover", 32'(rate_q.size()), 32'd0);
        check("status_leftover", 32'(stat_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
